mem_burst_master: RTL

MEM_BURST_MASTER -- requirements
Module: mem_burst_master

---
 rtl/mem_burst_master.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_burst_master.sv
// ---------------------------------------------------------------------------
// mem_burst_master
//
// Burst master for a simple single-port synchronous memory. A command
// (write/read, start address, beat count minus one) is accepted in IDLE.
// Write bursts take beats from the wr_* stream and drive one registered
// memory write per beat. Read bursts issue registered read addresses. At
// most two reads are outstanding or buffered at once. Returning data is
// captured into a 2-entry buffer and streamed out on rd_*.
//
// Memory timing assumed:
//   - write: memory samples addr/data_in on the edge ending a cycle with we=1
//   - read : data_out is valid in the cycle after addr holds the address
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   cmd_valid  in   command offered
//   cmd_ready  out  command accepted when cmd_valid & cmd_ready (IDLE only)
//   cmd_write  in   1 = write burst, 0 = read burst
//   cmd_addr   in   burst start address
//   cmd_len    in   beats minus one (0..255)
//   wr_data    in   write beat data
//   wr_valid   in   write beat offered
//   wr_ready   out  write beat accepted on wr_valid & wr_ready
//   rd_data    out  read beat data (stable while stalled)
//   rd_valid   out  read beat available
//   rd_ready   in   read beat consumed on rd_valid & rd_ready
//   we         out  memory write enable (registered)
//   addr       out  memory address (registered)
//   data_in    out  memory write data (registered)
//   data_out   in   memory read data
//   busy       out  high from the cycle after acceptance through done
//   done       out  one-cycle pulse at burst completion
// ---------------------------------------------------------------------------
module mem_burst_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Control state
  logic [1:0]        state_q,    state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;  // next address to issue
  logic [7:0]        cnt_q,      cnt_d;       // beats left to issue, minus one
  logic              wr_last_q,  wr_last_d;   // last write beat taken, in its we cycle

  // Memory-side registers
  logic              we_q,      we_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;

  // Read pipeline: pend1 = address on the bus this cycle,
  // pend2 = its data is on data_out this cycle.
  logic              pend1_q, pend1_d;
  logic              pend2_q, pend2_d;

  // 2-entry read return buffer
  logic [DATA_W-1:0] rbuf_mem_q [2];
  logic              rbuf_wr_ptr_q, rbuf_wr_ptr_d;
  logic              rbuf_rd_ptr_q, rbuf_rd_ptr_d;
  logic [1:0]        rbuf_cnt_q,    rbuf_cnt_d;

  logic       cmd_fire;
  logic       wr_fire;
  logic       rd_fire;
  logic       rbuf_push;
  logic [1:0] in_flight;
  logic       issue;
  logic       done_wr;
  logic       done_rd;

  assign cmd_ready = (state_q == ST_IDLE);
  // Once the last beat is taken the state stays WRITE for its we/done cycle,
  // so wr_ready must drop there to avoid taking a beat past the burst.
  assign wr_ready  = (state_q == ST_WRITE) && !wr_last_q;
  assign rd_valid  = (rbuf_cnt_q != 2'd0);
  assign rd_data   = rbuf_mem_q[rbuf_rd_ptr_q];

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wr_fire   = wr_valid && wr_ready;
  assign rd_fire   = rd_valid && rd_ready;
  assign rbuf_push = pend2_q;

  // Reads in the pipeline plus beats already buffered never exceed the
  // buffer depth, so a returning beat always has a free slot.
  assign in_flight = rbuf_cnt_q + {1'b0, pend1_q} + {1'b0, pend2_q};
  assign issue     = (state_q == ST_READ) && (in_flight < 2'd2);

  assign done_wr = (state_q == ST_WRITE) && wr_last_q;
  assign done_rd = (state_q == ST_DRAIN) && rd_fire && (rbuf_cnt_q == 2'd1)
                   && !pend1_q && !pend2_q;

  assign done    = done_wr || done_rd;
  assign busy    = (state_q != ST_IDLE);
  assign we      = we_q;
  assign addr    = addr_q;
  assign data_in = data_in_q;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    cnt_d         = cnt_q;
    wr_last_d     = wr_last_q;
    we_d          = 1'b0;
    addr_d        = addr_q;
    data_in_d     = data_in_q;
    pend1_d       = 1'b0;
    pend2_d       = pend1_q;
    rbuf_wr_ptr_d = rbuf_wr_ptr_q ^ rbuf_push;
    rbuf_rd_ptr_d = rbuf_rd_ptr_q ^ rd_fire;
    rbuf_cnt_d    = rbuf_cnt_q + {1'b0, rbuf_push} - {1'b0, rd_fire};

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          cur_addr_d = cmd_addr;
          cnt_d      = cmd_len;
          wr_last_d  = 1'b0;
          state_d    = cmd_write ? ST_WRITE : ST_READ;
        end
      end

      ST_WRITE: begin
        if (wr_last_q) begin
          // This is the last beat's we cycle; leave at its end.
          wr_last_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (wr_fire) begin
          we_d       = 1'b1;
          addr_d     = cur_addr_q;
          data_in_d  = wr_data;
          cur_addr_d = cur_addr_q + 1'b1;
          if (cnt_q == 8'd0) begin
            wr_last_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end

      ST_READ: begin
        if (issue) begin
          addr_d     = cur_addr_q;
          pend1_d    = 1'b1;
          cur_addr_d = cur_addr_q + 1'b1;
          if (cnt_q == 8'd0) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end

      ST_DRAIN: begin
        if (done_rd) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cur_addr_q    <= '0;
      cnt_q         <= '0;
      wr_last_q     <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      data_in_q     <= '0;
      pend1_q       <= 1'b0;
      pend2_q       <= 1'b0;
      rbuf_wr_ptr_q <= 1'b0;
      rbuf_rd_ptr_q <= 1'b0;
      rbuf_cnt_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      cnt_q         <= cnt_d;
      wr_last_q     <= wr_last_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      data_in_q     <= data_in_d;
      pend1_q       <= pend1_d;
      pend2_q       <= pend2_d;
      rbuf_wr_ptr_q <= rbuf_wr_ptr_d;
      rbuf_rd_ptr_q <= rbuf_rd_ptr_d;
      rbuf_cnt_q    <= rbuf_cnt_d;
    end
  end

  // NOTE: buffer storage is not reset; rd_valid comes from the reset
  // occupancy count, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (rbuf_push) begin
      rbuf_mem_q[rbuf_wr_ptr_q] <= data_out;
    end
  end

endmodule
